// File: rtl/c64_mem_bus.sv
// Memory/bus stage behind the 6502 core: 64 KB RAM, 6510 processor port and boot-preload FSM.
// Define C64_ROM_OVERLAY_EN to add the 8 KB KERNAL ROM overlay at $E000-$FFFF.
module c64_mem_bus #(
    parameter logic [15:0] LOAD_BASE  = 16'h0000,
    parameter int unsigned RESET_HOLD = 4,
    parameter logic [7:0]  DDR_INIT   = 8'h2F,
    parameter logic [7:0]  PORT_INIT  = 8'h37
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cpu_di,
    output logic        cpu_reset,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic        ld_done,
`ifdef C64_ROM_OVERLAY_EN
    input  logic        ld_rom,
`endif
    input  logic [7:0]  port_in,
    output logic [7:0]  port_out
);

    typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;

    state_t      state_q;
    logic        cpu_reset_q;
    logic        ld_ready_q;
    logic [15:0] ld_addr_q;
    logic [7:0]  hold_cnt_q;
    logic [7:0]  ddr_q;
    logic [7:0]  port_q;
    logic [7:0]  ram_q [0:65535];

    logic        ram_we_d;
    logic [15:0] ram_addr_d;
    logic [7:0]  ram_wdata_d;
    logic        rom_sel;

`ifdef C64_ROM_OVERLAY_EN
    logic [7:0]  rom_q [0:8191];
    logic        rom_we_d;
    assign rom_sel = ld_rom;
`else
    assign rom_sel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            cpu_reset_q <= 1'b1;
            ld_ready_q  <= 1'b1;
            ld_addr_q   <= LOAD_BASE;
            hold_cnt_q  <= 8'h00;
            ddr_q       <= DDR_INIT;
            port_q      <= PORT_INIT;
        end else begin
            case (state_q)
                LOAD: begin
                    if (ld_valid) ld_addr_q <= ld_addr_q + 16'd1;
                    if (ld_done) begin
                        state_q    <= HOLD;
                        ld_ready_q <= 1'b0;
                        hold_cnt_q <= 8'(RESET_HOLD - 1);
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == 8'h00) begin
                        state_q     <= RUN;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                RUN: begin
                    if (cpu_we && cpu_ab == 16'h0000) ddr_q  <= cpu_do;
                    if (cpu_we && cpu_ab == 16'h0001) port_q <= cpu_do;
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    // One shared write port: the preload stream owns it in LOAD, the core in RUN.
    always_comb begin
        ram_we_d    = 1'b0;
        ram_addr_d  = cpu_ab;
        ram_wdata_d = cpu_do;
`ifdef C64_ROM_OVERLAY_EN
        rom_we_d    = 1'b0;
`endif
        if (!reset) begin
            if (state_q == LOAD && ld_valid) begin
                ram_addr_d  = ld_addr_q;
                ram_wdata_d = ld_data;
                ram_we_d    = !rom_sel;
`ifdef C64_ROM_OVERLAY_EN
                rom_we_d    = rom_sel;
`endif
            end else if (state_q == RUN && cpu_we) begin
                ram_we_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we_d) ram_q[ram_addr_d] <= ram_wdata_d;
    end

`ifdef C64_ROM_OVERLAY_EN
    always_ff @(posedge clk) begin
        if (rom_we_d) rom_q[ram_addr_d[12:0]] <= ram_wdata_d;
    end
`endif

    // Port registers shadow RAM[$0000]/[$0001], so they always win the read mux.
    always_comb begin
        cpu_di = ram_q[cpu_ab];
`ifdef C64_ROM_OVERLAY_EN
        if (cpu_ab[15:13] == 3'b111 && port_q[1]) cpu_di = rom_q[cpu_ab[12:0]];
`endif
        if (cpu_ab == 16'h0000)      cpu_di = ddr_q;
        else if (cpu_ab == 16'h0001) cpu_di = (port_q & ddr_q) | (port_in & ~ddr_q);
    end

    assign port_out  = port_q & ddr_q;
    assign cpu_reset = cpu_reset_q;
    assign ld_ready  = ld_ready_q;

endmodule

// File: tb/tb_c64_mem_bus.sv
// Directed bench for c64_mem_bus: preload, hold timing, processor port, RAM access, reset and ROM overlay.
module tb_c64_mem_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic        cpu_we;
    logic [7:0]  cpu_do;
    logic [7:0]  port_in;
    logic [7:0]  cpu_di, port_out;
    logic        cpu_reset, ld_ready;
    logic        ld_valid, ld_done, ld_rom;
    logic [7:0]  ld_data;

    logic [7:0]  cpu_di2, port_out2, ld_data2;
    logic        cpu_reset2, ld_ready2, ld_valid2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    c64_mem_bus dut (
        .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
        .cpu_di(cpu_di), .cpu_reset(cpu_reset), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done),
`ifdef C64_ROM_OVERLAY_EN
        .ld_rom(1'b0),
`endif
        .port_in(port_in), .port_out(port_out)
    );

    // Second instance exercises the 16-bit wrap of the load address.
    c64_mem_bus #(.LOAD_BASE(16'hFFFE)) dut2 (
        .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
        .cpu_di(cpu_di2), .cpu_reset(cpu_reset2), .ld_valid(ld_valid2), .ld_data(ld_data2),
        .ld_ready(ld_ready2), .ld_done(1'b0),
`ifdef C64_ROM_OVERLAY_EN
        .ld_rom(1'b0),
`endif
        .port_in(port_in), .port_out(port_out2)
    );

`ifdef C64_ROM_OVERLAY_EN
    logic [7:0] cpu_di3, port_out3, ld_data3;
    logic       cpu_reset3, ld_ready3, ld_valid3, ld_done3, ld_rom3;

    c64_mem_bus #(.LOAD_BASE(16'hFFFC)) dut3 (
        .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
        .cpu_di(cpu_di3), .cpu_reset(cpu_reset3), .ld_valid(ld_valid3), .ld_data(ld_data3),
        .ld_ready(ld_ready3), .ld_done(ld_done3), .ld_rom(ld_rom3),
        .port_in(port_in), .port_out(port_out3)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] ab, input logic we, input logic [7:0] wd,
                                 input logic valid, input logic [7:0] data, input logic done);
        cpu_ab   = ab;
        cpu_we   = we;
        cpu_do   = wd;
        ld_valid = valid;
        ld_data  = data;
        ld_done  = done;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; cpu_ab = 16'h0000; cpu_we = 1'b0; cpu_do = 8'h00; port_in = 8'hA0;
        ld_valid = 1'b0; ld_data = 8'h00; ld_done = 1'b0; ld_rom = 1'b0;
        ld_valid2 = 1'b0; ld_data2 = 8'h00;
`ifdef C64_ROM_OVERLAY_EN
        ld_valid3 = 1'b0; ld_data3 = 8'h00; ld_done3 = 1'b0; ld_rom3 = 1'b0;
`endif
        tick(); tick();
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_cpu_reset", cpu_reset, 1'b1);
        checkOutput("rst_ld_ready", ld_ready, 1'b1);
        checkOutput("rst_port_out", port_out, 8'h27);
        checkOutput("rst_ddr_read", cpu_di, 8'h2F);
        cpu_ab = 16'h0001; #1;
        checkOutput("rst_port_read", cpu_di, 8'hA7);

        $display("[TB] load address wrap");
        ld_valid2 = 1'b1; ld_data2 = 8'h11; tick();
        ld_data2 = 8'h22; tick();
        ld_data2 = 8'h33; tick();
        ld_valid2 = 1'b0;
        checkOutput("wrap_fffe", dut2.ram_q[16'hFFFE], 8'h11);
        checkOutput("wrap_ffff", dut2.ram_q[16'hFFFF], 8'h22);
        checkOutput("wrap_0000", dut2.ram_q[16'h0000], 8'h33);

        $display("[TB] preload and hold");
        applyStimulus(16'h0000, 1'b0, 8'h00, 1'b1, 8'hA9, 1'b0);
        applyStimulus(16'h0000, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0);
        applyStimulus(16'h0000, 1'b0, 8'h00, 1'b1, 8'h85, 1'b0);
        applyStimulus(16'h0000, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0);
        checkOutput("pre_done_ready", ld_ready, 1'b1);
        applyStimulus(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        checkOutput("hold_ready", ld_ready, 1'b0);
        checkOutput("hold_rst0", cpu_reset, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            checkOutput($sformatf("hold_rst%0d", i), cpu_reset, 1'b1);
        end
        applyStimulus(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("run_rst", cpu_reset, 1'b0);
        checkOutput("ram_0", dut.ram_q[16'h0000], 8'hA9);
        checkOutput("ram_1", dut.ram_q[16'h0001], 8'h05);
        checkOutput("ram_2", dut.ram_q[16'h0002], 8'h85);
        checkOutput("ram_3", dut.ram_q[16'h0003], 8'h10);
        checkOutput("ddr_untouched", cpu_di, 8'h2F);

        $display("[TB] processor port");
        applyStimulus(16'h0000, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
        applyStimulus(16'h0001, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0);
        cpu_we = 1'b0; cpu_ab = 16'h0001; #1;
        checkOutput("port_read_ff", cpu_di, 8'h05);
        checkOutput("port_out_ff", port_out, 8'h05);
        applyStimulus(16'h0000, 1'b1, 8'h0F, 1'b0, 8'h00, 1'b0);
        cpu_we = 1'b0; cpu_ab = 16'h0001; #1;
        checkOutput("port_read_0f", cpu_di, 8'hA5);
        checkOutput("port_out_0f", port_out, 8'h05);
        cpu_ab = 16'h0000; #1;
        checkOutput("ddr_read_0f", cpu_di, 8'h0F);

        $display("[TB] RAM read after write");
        applyStimulus(16'hC000, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
        cpu_we = 1'b0; #1;
        checkOutput("raw_c000", cpu_di, 8'h5A);

        $display("[TB] reset in RUN and mid-stream");
        reset = 1'b1;
        applyStimulus(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        checkOutput("rrun_cpu_reset", cpu_reset, 1'b1);
        checkOutput("rrun_ld_ready", ld_ready, 1'b1);
        checkOutput("rrun_ddr", cpu_di, 8'h2F);
        checkOutput("rrun_port_out", port_out, 8'h27);
        applyStimulus(16'h0000, 1'b0, 8'h00, 1'b1, 8'hC1, 1'b0);
        applyStimulus(16'h0000, 1'b0, 8'h00, 1'b1, 8'hC2, 1'b0);
        reset = 1'b1;
        applyStimulus(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        checkOutput("rmid_cpu_reset", cpu_reset, 1'b1);
        checkOutput("rmid_ld_ready", ld_ready, 1'b1);
        checkOutput("rmid_keep0", dut.ram_q[16'h0000], 8'hC1);
        checkOutput("rmid_keep1", dut.ram_q[16'h0001], 8'hC2);
        applyStimulus(16'h0000, 1'b0, 8'h00, 1'b1, 8'hD1, 1'b0);
        checkOutput("rmid_base", dut.ram_q[16'h0000], 8'hD1);
        checkOutput("rmid_next", dut.ram_q[16'h0001], 8'hC2);

        $display("[TB] CPU write ignored during HOLD");
        applyStimulus(16'hC000, 1'b1, 8'h99, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(16'hC000, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
        cpu_we = 1'b0; #1;
        checkOutput("hold_we_rst", cpu_reset, 1'b0);
        checkOutput("hold_we_c000", cpu_di, 8'h5A);

`ifdef C64_ROM_OVERLAY_EN
        $display("[TB] ROM overlay");
        reset = 1'b1; tick(); reset = 1'b0;
        ld_valid3 = 1'b1; ld_rom3 = 1'b1; ld_data3 = 8'hE2; tick();
        ld_valid3 = 1'b0; ld_rom3 = 1'b0; ld_done3 = 1'b1; tick();
        ld_done3 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("rom_run", cpu_reset3, 1'b0);
        applyStimulus(16'hFFFC, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
        cpu_we = 1'b0; #1;
        checkOutput("rom_ram_written", dut3.ram_q[16'hFFFC], 8'h77);
        checkOutput("rom_read_37", cpu_di3, 8'hE2);
        applyStimulus(16'h0001, 1'b1, 8'h35, 1'b0, 8'h00, 1'b0);
        cpu_we = 1'b0; cpu_ab = 16'hFFFC; #1;
        checkOutput("rom_read_35", cpu_di3, 8'h77);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c64_mem_bus.md
Name: c64_mem_bus

Overview:
- Memory and bus stage directly downstream of the 6502 core. It consumes the core's address, write enable and write data, and returns read data.
- Contains a 64 KB RAM and the 6510 processor port ($0000 DDR, $0001 PORT).
- Contains a boot-preload FSM. The FSM holds the CPU in reset while a byte stream fills RAM, then releases the CPU.

Parameters:
- LOAD_BASE, 16'h0000, first RAM address written by the preload stream.
- RESET_HOLD, 4, cycles cpu_reset stays high after ld_done (legal range 1..255).
- DDR_INIT, 8'h2F, reset value of the DDR register.
- PORT_INIT, 8'h37, reset value of the PORT register.

Ports:
- clk  in  1  single system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_ab  in  16  address from the core.
- cpu_we  in  1  write strobe from the core.
- cpu_do  in  8  write data from the core.
- cpu_di  out  8  read data to the core.
- cpu_reset  out  1  reset to the core, high while preloading/holding.
- ld_valid  in  1  preload byte valid.
- ld_data  in  8  preload byte.
- ld_ready  out  1  block accepts preload bytes.
- ld_done  in  1  end of preload stream (single-cycle pulse).
- port_in  in  8  external levels on processor-port pins.
- port_out  out  8  driven port pins: PORT & DDR.

Behaviour:
Interface:
- One clock `clk`; reset is synchronous and active-high on `reset`.

Reset (applies at any time, including mid-load or mid-run):
- State becomes LOAD.
- cpu_reset=1, ld_ready=1, ld_addr=LOAD_BASE, hold_cnt=0, DDR=DDR_INIT, PORT=PORT_INIT.
- RAM contents are not cleared.

FSM states:
- LOAD:
  - ld_ready=1 and cpu_reset=1.
  - On ld_valid, write RAM[ld_addr]=ld_data and increment ld_addr by 1. Increment is 16-bit and wraps FFFF->0000.
  - On ld_done, go to HOLD and load hold_cnt=RESET_HOLD-1.
  - ld_valid and ld_done in the same cycle: the byte is written, then the transition happens.
- HOLD:
  - ld_ready=0, cpu_reset=1. ld_valid is ignored.
  - hold_cnt decrements each cycle; when hold_cnt==0, go to RUN.
  - Result: cpu_reset is high for exactly RESET_HOLD cycles after the ld_done edge.
- RUN:
  - ld_ready=0, cpu_reset=0. ld_valid and ld_done are ignored.
  - The block stays in RUN until reset.

CPU access (honoured in RUN only; cpu_we is ignored in LOAD/HOLD):
- Read:
  - cpu_di is combinational from the current cpu_ab, so the core samples it on the next edge.
  - $0000 returns DDR.
  - $0001 returns (PORT & DDR) | (port_in & ~DDR).
  - All other addresses return the overlay or RAM per the Optional Feature.
- Write:
  - On posedge with cpu_we=1, $0000 -> DDR and $0001 -> PORT.
  - RAM[$0000]/RAM[$0001] are also written with the same byte; they are shadowed but never read back.
  - All other addresses -> RAM. Writes under ROM always land in RAM.
- Read-after-write of the same address in the next cycle returns the new value.
- cpu_di in LOAD/HOLD: same combinational decode. Its value is don't-care to the core, which is in reset.

Optional Feature:
- Macro: C64_ROM_OVERLAY_EN.
- Defined:
  - Adds an 8 KB KERNAL ROM array plus a ld_rom input (1 bit).
  - In LOAD, a byte with ld_rom=1 goes to ROM[ld_addr[12:0]] instead of RAM. ld_addr still increments.
  - In RUN, a read of $E000-$FFFF returns ROM when PORT[1]==1, otherwise RAM.
  - Writes to $E000-$FFFF always go to RAM.
- Undefined:
  - No ROM array and no ld_rom port; every non-port address reads RAM.

Test Plan:
1. Preload $0000..$0003 = A9 05 85 10, then ld_done:
   - ld_ready drops the cycle after ld_done.
   - cpu_reset is high for exactly 4 further cycles, then low.
   - RAM holds the 4 bytes.
2. LOAD_BASE=16'hFFFE; stream 3 bytes 11 22 33:
   - RAM[FFFE]=11, RAM[FFFF]=22, RAM[0000]=33 (address wrap).
3. In RUN, CPU writes 8'hFF to $0000, then 8'h05 to $0001, port_in=8'hA0:
   - Read $0001 returns 8'h05; port_out=8'h05.
   - Then write DDR=8'h0F: read $0001 returns 8'hA5.
4. In RUN, write 8'h5A to $C000, then read $C000 next cycle -> 8'h5A.
   - cpu_we asserted during HOLD to $C000 with 8'h99 -> RAM unchanged.
5. Assert reset mid-stream after 2 of 4 bytes:
   - State returns to LOAD, ld_addr=LOAD_BASE, cpu_reset=1, DDR=2F, PORT=37.
   - The 2 written bytes are retained.
6. With C64_ROM_OVERLAY_EN:
   - Load ROM[1FFC]=E2 via ld_rom=1; write RAM $FFFC=77.
   - Read $FFFC gives E2 with PORT=37, and 77 after PORT=35.
